serdes_tx_arbiter: RTL and testbench
====================================

Name: serdes_tx_arbiter

Overview:
- Round-robin arbiter that shares the single 8-bit PISO serializer input between NUM_REQ byte-stream requesters.
- Each grant produces one packet for the PISO: a header byte tagging the requester ID, then that requester's payload bytes.
- A packet ends on the requester's last flag or when MAX_BURST payload bytes have been sent.
- Sits in the pclk_i domain, directly upstream of the PISO parallel valid/ready interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_BURST, 8, max payload bytes per grant (1..255).
- HDR_TAG, 4'hA, upper nibble of every header byte.

Ports:
- pclk_i  input  1  parallel-domain clock; all logic rising-edge.
- rst_i  input  1  asynchronous, active-low reset.
- req_data_i  input  8*NUM_REQ  payload byte of requester k in bits [8k+7:8k].
- req_valid_i  input  NUM_REQ  per-requester byte valid.
- req_last_i  input  NUM_REQ  per-requester last-byte-of-packet flag, qualified by valid.
- req_ready_o  output  NUM_REQ  per-requester byte accepted.
- tx_data_o  output  8  byte to PISO data_i.
- tx_valid_o  output  1  to PISO valid_i.
- tx_ready_i  input  1  from PISO ready_o.
- grant_o  output  NUM_REQ  one-hot current owner; 0 when idle.
- busy_o  output  1  high in HDR or DATA.

Behaviour:
- Reset values (asynchronous on rst_i low):
  - state=IDLE, grant_o=0, rr_ptr=0, beat_cnt=0.
  - tx_valid_o=0, tx_data_o=0, req_ready_o=0, busy_o=0.
- Handshake: a transfer occurs on a pclk_i edge where tx_valid_o && tx_ready_i.
  - Once asserted, tx_valid_o and tx_data_o stay stable until the transfer completes. This holds in HDR; in DATA it follows from the requester obeying the same rule.
- FSM IDLE -> HDR -> DATA -> IDLE.
- IDLE:
  - req_ready_o=0, tx_valid_o=0.
  - If any req_valid_i bit is set, select the first set bit searching from rr_ptr upward with wrap.
  - Register that bit as grant_o (one-hot) and its index as gid; clear beat_cnt; go to HDR.
  - Arbitration takes 1 cycle; the header is presented the cycle after a request is first seen.
- HDR:
  - tx_valid_o=1, tx_data_o={HDR_TAG, gid[3:0]}, req_ready_o=0.
  - On transfer, go to DATA.
- DATA (combinational pass-through of the granted requester only):
  - tx_valid_o = req_valid_i[gid].
  - tx_data_o = req_data_i[gid].
  - req_ready_o[gid] = tx_ready_i; all other req_ready_o bits are 0.
  - On each transfer, beat_cnt increments.
  - Return to IDLE if req_last_i[gid] is set or beat_cnt == MAX_BURST-1 (the byte just sent was the MAX_BURST-th).
  - On leaving DATA: rr_ptr = (gid+1) mod NUM_REQ, grant_o cleared.
- Stall: if the granted requester drops valid mid-packet, hold the grant indefinitely (no timeout); tx_valid_o=0 during the gap.
- Truncation by MAX_BURST:
  - The remaining bytes stay in the requester and no data is lost.
  - The requester re-arbitrates and gets a fresh header.
  - Downstream treats consecutive same-ID packets as concatenated.
- Requests from non-granted requesters are ignored until IDLE; their req_ready_o stays 0.
- Simultaneous requests: strict round-robin. With all NUM_REQ requesting continuously, grant order is rr_ptr, rr_ptr+1, ... with wrap.
- last together with the MAX_BURST boundary on the same byte: a single exit to IDLE, with no extra empty packet.
- Width: beat_cnt is 8 bits; gid is clog2(NUM_REQ) bits, zero-extended into the header nibble.
- Reset mid-packet: returns immediately to reset values. The partial packet is abandoned; the requester must re-send from packet start.

Test Plan:
- Single requester: req1 sends 0x11,0x22,0x33 (last on 0x33), tx_ready_i=1 -> tx sees 0xA1,0x11,0x22,0x33; grant_o=4'b0010 during; IDLE after; rr_ptr=2.
- All four request 1-byte packets (last=1) simultaneously from reset -> headers 0xA0,0xA1,0xA2,0xA3 in order; each followed by its payload byte; 8 transfers total.
- MAX_BURST=8: req2 offers 10 bytes 0x00..0x09, last on 0x09, others idle -> 0xA2,0x00..0x07, IDLE, then 0xA2,0x08,0x09.
- Back-pressure: tx_ready_i low for 3 cycles while the header is presented -> tx_valid_o=1 and tx_data_o=0xA0 held constant all 3 cycles; single transfer when ready rises.
- Requester valid gap: req0 drops valid for 5 cycles after its 2nd byte while req3 requests -> grant_o stays 4'b0001; tx_valid_o=0 during the gap; req_ready_o[3]=0 throughout.
- Async reset asserted in DATA after 2 bytes -> all outputs 0 without a clock edge. After release, arbitration restarts with rr_ptr=0 and a fresh header.

Source files
------------

// File: rtl/serdes_tx_arbiter.sv
// serdes_tx_arbiter
//   Round-robin arbiter in front of the 8-bit PISO serializer. Each grant emits
//   one packet: a header byte {HDR_TAG, gid}, then the granted requester's bytes
//   passed straight through. A packet ends on the requester's last flag or after
//   MAX_BURST payload bytes, whichever comes first.
//
// Ports
//   pclk_i       parallel-domain clock, rising edge
//   rst_i        asynchronous reset, active low
//   req_data_i   payload byte of requester k in bits [8k+7:8k]
//   req_valid_i  per-requester byte valid
//   req_last_i   per-requester last-byte flag, qualified by valid
//   req_ready_o  per-requester byte accepted
//   tx_data_o    byte to the PISO
//   tx_valid_o   valid to the PISO
//   tx_ready_i   ready from the PISO
//   grant_o      one-hot current owner, 0 when idle
//   busy_o       high while a packet (header or payload) is in flight

module serdes_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 8,
    parameter logic [3:0]  HDR_TAG   = 4'hA
) (
    input  logic                 pclk_i,
    input  logic                 rst_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o
);

    localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    state_e               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [GID_W-1:0]     r_gid, w_gid_nxt;
    logic [GID_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [7:0]           r_beat_cnt, w_beat_cnt_nxt;

    logic                 w_arb_found;
    logic [GID_W-1:0]     w_arb_idx;
    logic [NUM_REQ-1:0]   w_arb_onehot;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [7:0]           w_sel_data;
    logic [3:0]           w_gid_nib;
    logic [GID_W-1:0]     w_gid_inc;

    // Round-robin pick: first pass covers rr_ptr..NUM_REQ-1, second pass wraps
    // to the low indices. Loop-constant indices keep the selects width-clean.
    always_comb begin
        w_arb_found  = 1'b0;
        w_arb_idx    = '0;
        w_arb_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_arb_found && req_valid_i[k] && (GID_W'(k) >= r_rr_ptr)) begin
                w_arb_found     = 1'b1;
                w_arb_idx       = GID_W'(k);
                w_arb_onehot[k] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_arb_found && req_valid_i[k]) begin
                w_arb_found     = 1'b1;
                w_arb_idx       = GID_W'(k);
                w_arb_onehot[k] = 1'b1;
            end
        end
    end

    // Mux of the granted requester's stream.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_gid == GID_W'(k)) begin
                w_sel_valid = req_valid_i[k];
                w_sel_last  = req_last_i[k];
                w_sel_data  = req_data_i[8*k +: 8];
            end
        end
    end

    assign w_gid_nib = 4'(r_gid);
    assign w_gid_inc = (r_gid == GID_W'(NUM_REQ - 1)) ? '0 : r_gid + 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_gid_nxt      = r_gid;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        req_ready_o    = '0;
        tx_valid_o     = 1'b0;
        tx_data_o      = '0;

        unique case (r_state)
            StIdle: begin
                if (w_arb_found) begin
                    w_grant_nxt    = w_arb_onehot;
                    w_gid_nxt      = w_arb_idx;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = StHdr;
                end
            end
            StHdr: begin
                tx_valid_o = 1'b1;
                tx_data_o  = {HDR_TAG, w_gid_nib};
                if (tx_ready_i) begin
                    w_state_nxt = StData;
                end
            end
            StData: begin
                tx_valid_o  = w_sel_valid;
                tx_data_o   = w_sel_data;
                // r_grant is one-hot on gid, so this gates ready to the owner only.
                req_ready_o = r_grant & {NUM_REQ{tx_ready_i}};
                if (w_sel_valid && tx_ready_i) begin
                    w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                    // last and the burst limit on the same byte give one exit only.
                    if (w_sel_last || (r_beat_cnt == 8'(MAX_BURST - 1))) begin
                        w_state_nxt  = StIdle;
                        w_grant_nxt  = '0;
                        w_rr_ptr_nxt = w_gid_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign grant_o = r_grant;
    assign busy_o  = (r_state != StIdle);

    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= StIdle;
            r_grant    <= '0;
            r_gid      <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_gid      <= w_gid_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// tb_serdes_tx_arbiter
//   Requester queues feed the DUT; every packet queued also pushes its expected
//   {grant, byte} sequence to a scoreboard that is popped on each PISO transfer.
//   Inputs change at posedge+1; transfers are observed at the negedge before
//   the edge that commits them.

module tb_serdes_tx_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_BURST = 8;

    logic                 pclk = 1'b0;
    logic                 rst_n;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;

    logic [8:0]  rq [NUM_REQ][$];
    logic [11:0] sb [$];
    logic [NUM_REQ-1:0] hold;
    int n_checks = 0;
    int n_fail   = 0;

    serdes_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST),
        .HDR_TAG   (4'hA)
    ) u_dut (
        .pclk_i      (pclk),
        .rst_i       (rst_n),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Queue a packet of n bytes base, base+step, ... with last on the final one,
    // and the expected PISO stream including a fresh header every MAX_BURST bytes.
    task automatic push_pkt(input int k, input int n, input logic [7:0] base,
                            input logic [7:0] step);
        logic [7:0] b;
        logic [3:0] oh;
        oh = 4'(1 << k);
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i) * step;
            if (i % MAX_BURST == 0) sb.push_back({oh, 8'hA0 | 8'(k)});
            sb.push_back({oh, b});
            rq[k].push_back({1'(i == n - 1), b});
        end
    endtask

    task automatic wait_sb(input string tag);
        int c = 0;
        while (sb.size() != 0 && c < 300) begin
            @(negedge pclk);
            c++;
        end
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    task automatic expect_idle(input string tag);
        repeat (2) @(negedge pclk);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_txv"}, tx_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst_n = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) rq[k].delete();
        sb.delete();
        hold = '0;
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
    endtask

    task automatic wait_rq_size(input string tag, input int k, input int sz);
        int c = 0;
        while (rq[k].size() != sz && c < 100) begin
            @(negedge pclk);
            c++;
        end
        check(tag, rq[k].size(), sz);
    endtask

    // Requester models plus transfer monitor.
    initial begin : bfm
        logic [NUM_REQ-1:0] acc;
        logic [11:0] exp_e;
        logic [8:0]  h;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge pclk);
            acc = req_ready & req_valid;
            if (tx_valid && tx_ready) begin
                check("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    check("tx_byte", {20'h0, grant, tx_data}, {20'h0, exp_e});
                end
            end
            @(posedge pclk);
            #1;
            if (rst_n) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (acc[k] && rq[k].size() != 0) void'(rq[k].pop_front());
                end
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (rq[k].size() != 0 && !hold[k]) begin
                    h = rq[k][0];
                    req_valid[k]        = 1'b1;
                    req_data[8*k +: 8]  = h[7:0];
                    req_last[k]         = h[8];
                end else begin
                    req_valid[k]        = 1'b0;
                    req_data[8*k +: 8]  = 8'h00;
                    req_last[k]         = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c;
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        hold     = '0;
        #3;
        check("rst_txv", tx_valid, 0);
        check("rst_txd", tx_data, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;

        // Single requester, 3-byte packet.
        @(negedge pclk);
        push_pkt(1, 3, 8'h11, 8'h11);
        wait_sb("t1_done");
        expect_idle("t1");

        // rr_ptr is now 2: req2 must beat req0.
        push_pkt(2, 1, 8'h55, 8'h00);
        push_pkt(0, 1, 8'h66, 8'h00);
        wait_sb("rr_done");
        expect_idle("rr");

        // All four from reset, strict order 0..3.
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) push_pkt(k, 1, 8'hB0 + 8'(k), 8'h00);
        wait_sb("all4_done");
        expect_idle("all4");

        // Truncation at MAX_BURST with a second header.
        push_pkt(2, 10, 8'h00, 8'h01);
        wait_sb("burst_done");
        expect_idle("burst");

        // last on the MAX_BURST-th byte: single exit, no empty packet.
        push_pkt(3, 8, 8'hC0, 8'h01);
        wait_sb("lastmax_done");
        expect_idle("lastmax");

        // Back-pressure on the header.
        tx_ready = 1'b0;
        push_pkt(0, 1, 8'h77, 8'h00);
        c = 0;
        while (!tx_valid && c < 20) begin
            @(negedge pclk);
            c++;
        end
        for (int i = 0; i < 3; i++) begin
            check("bp_txv", tx_valid, 1);
            check("bp_txd", tx_data, 8'hA0);
            check("bp_grant", grant, 4'b0001);
            @(negedge pclk);
        end
        @(posedge pclk);
        #1;
        tx_ready = 1'b1;
        wait_sb("bp_done");
        expect_idle("bp");

        // Requester gap: req0 stalls after its 2nd byte while req3 waits.
        do_reset();
        push_pkt(0, 4, 8'h01, 8'h01);
        push_pkt(3, 1, 8'hD3, 8'h00);
        wait_rq_size("gap_sync", 0, 3);
        hold[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            check("gap_grant", grant, 4'b0001);
            check("gap_txv", tx_valid, 0);
            check("gap_ready3", req_ready[3], 0);
        end
        hold[0] = 1'b0;
        wait_sb("gap_done");
        expect_idle("gap");

        // Leave rr_ptr at 3 so a stale pointer after reset would favour req3.
        push_pkt(2, 1, 8'h99, 8'h00);
        wait_sb("pre_rst_done");
        expect_idle("pre_rst");

        // Asynchronous reset in DATA after two payload bytes.
        push_pkt(1, 5, 8'h21, 8'h01);
        wait_rq_size("mid_sync", 1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_txv", tx_valid, 0);
        check("mid_txd", tx_data, 0);
        check("mid_ready", req_ready, 0);
        check("mid_grant", grant, 0);
        check("mid_busy", busy, 0);
        for (int k = 0; k < NUM_REQ; k++) rq[k].delete();
        sb.delete();
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        push_pkt(1, 3, 8'h21, 8'h01);
        push_pkt(3, 1, 8'hE3, 8'h00);
        wait_sb("post_rst_done");
        expect_idle("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
